cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle instruction sequencer for the 16-bit RISC core. It walks each instruction through fetch, decode, execute, optional multiply/divide wait, optional memory access and writeback. It consumes the decoded `is*` flags from the control unit and handshakes with instruction memory, data memory and the iterative multiply/divide/mod unit. It produces the register-file, flag, IR and PC load strobes that advance the datapath.

## Interface
- `MD_TIMEOUT`, 32: max cycles spent in MDWAIT before abort (used only with `SEQ_MD_TIMEOUT_EN`).
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `halt_req`  in  1  request stop at next instruction boundary
- `imem_ack`  in  1  instruction word valid (sampled only in FETCH)
- `dmem_ack`  in  1  data access complete (sampled only in MEM)
- `md_done`  in  1  mul/div/mod result ready (sampled only in MDWAIT)
- `isLd, isSt, isMul, isDiv, isMod, isCmp, isWb, isBeq, isBgt, isUBranch`  in  1 each  decoded flags, stable DECODE..WB
- `flag_eq, flag_gt`  in  1 each  comparison flags from flags register
- `imem_req`  out  1  instruction fetch request
- `dmem_req`  out  1  data memory request
- `dmem_we`  out  1  data memory write (store)
- `md_start`  out  1  one-cycle start pulse to mul/div/mod unit
- `ir_load`  out  1  latch fetched word into IR
- `rf_we`  out  1  register-file write strobe
- `flags_we`  out  1  flags register write strobe
- `pc_load`  out  1  update PC
- `pc_sel`  out  1  0 = PC+1, 1 = branch/call/ret target
- `retire`  out  1  one-cycle pulse per completed instruction
- `halted`  out  1  sequencer in HALT
- `md_err`  out  1  sticky mul/div timeout error
- `state`  out  3  current state (debug)
- `instr_count`  out  16  retired-instruction counter

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MDWAIT=3, MEM=4, WB=5, HALT=6. Value 7 is illegal and goes to HALT.
- HALT (reset state): all strobes low, `halted`=1. Goes to FETCH when `halt_req`=0.
- FETCH: `imem_req`=1 until `imem_ack`. On ack: `ir_load`=1 that cycle, then DECODE.
- DECODE: one cycle for the control unit to settle on the new IR, then EXEC.
- EXEC:
  - isMul|isDiv|isMod: `md_start`=1, go to MDWAIT.
  - else isLd|isSt: go to MEM.
  - else: go to WB.
- MDWAIT: wait for `md_done`, then WB.
- MEM: `dmem_req`=1, `dmem_we`=isSt, until `dmem_ack`, then WB.
- WB (one cycle):
  - `rf_we`=isWb (forced 0 if this instruction timed out).
  - `flags_we`=isCmp.
  - `pc_load`=1.
  - `pc_sel` = isUBranch | (isBeq & flag_eq) | (isBgt & flag_gt).
  - `retire`=1; `instr_count` increments, wrapping 0xFFFF→0x0000.
  - Next state is HALT if `halt_req`=1, else FETCH.
- NOP (all flags 0) passes EXEC→WB with `rf_we`=0 and PC+1.
- `halt_req` takes effect only in WB or HALT, so an in-flight instruction always completes.
- Ack inputs outside their sampling state are ignored. `md_done` in the same cycle as `md_start` is ignored.

## Timing
- Reset values: state=HALT, `halted`=1, `instr_count`=0, `md_err`=0, all other outputs 0. The first FETCH is one cycle after `rst_n` rises, given `halt_req`=0.
- Strobes are Moore-decoded from state plus the stable decoded flags. No output depends on an ack in the same cycle except `ir_load`.
- Minimum latency with zero-wait acks: ALU/branch/NOP 4 cycles (F,D,E,W); LD/ST 5 cycles; MUL/DIV/MOD 5 cycles + MDWAIT cycles beyond the first.
- Back-to-back: `retire` pulses at most once every 4 cycles.
- Reset mid-instruction: immediate return to reset values; no partial strobes.

## Configuration
- `SEQ_MD_TIMEOUT_EN` defined:
  - An MDWAIT counter, width $clog2(MD_TIMEOUT+1), clears on entry.
  - If `md_done` has not arrived after `MD_TIMEOUT` cycles, `md_err` is set (sticky until reset) and the sequencer goes to WB with `rf_we` suppressed.
  - PC still advances and `retire` still pulses.
- Undefined: MDWAIT waits indefinitely, no counter logic, `md_err` tied 0.

## Test plan
- Reset, `halt_req`=0, ADD flags (isWb=1), zero-wait acks -> states 6,0,1,2,5,0; `rf_we`/`pc_load`/`retire` high in WB; `pc_sel`=0; `instr_count`=1.
- LD with `dmem_ack` delayed 3 cycles -> `dmem_req` high 4 cycles, `dmem_we`=0, `rf_we`=1 in WB. ST identical with `dmem_we`=1 and `rf_we`=0.
- BEQ with `flag_eq`=1 -> `pc_sel`=1. BEQ with `flag_eq`=0 -> `pc_sel`=0. BGT with `flag_gt`=1 -> `pc_sel`=1. CMP -> `flags_we`=1, `rf_we`=0.
- MUL, `md_done` asserted in EXEC and again 5 cycles later -> the first is ignored; WB follows the second; `md_start` is exactly one pulse.
- With `SEQ_MD_TIMEOUT_EN`, `MD_TIMEOUT`=8, `md_done` never asserted -> `md_err`=1 after 8 MDWAIT cycles, WB with `rf_we`=0, `retire`=1, sticky across the next instructions.
- `halt_req` raised during FETCH of a DIV -> DIV completes, state 6 after WB, `halted`=1. Drop `halt_req` -> FETCH next cycle. Preload 0xFFFF retirements -> the next one wraps `instr_count` to 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer for the 16-bit RISC core.
// Walks each instruction through FETCH, DECODE, EXEC, MDWAIT, MEM and WB, and
// produces the IR/PC/register-file/flag load strobes that advance the datapath.
// Optional feature macro: SEQ_MD_TIMEOUT_EN adds an MDWAIT watchdog that aborts
// a mul/div/mod after MD_TIMEOUT cycles and raises the sticky md_err flag.
module cpu_sequencer #(
  parameter int MD_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        md_done,
  input  logic        isLd,
  input  logic        isSt,
  input  logic        isMul,
  input  logic        isDiv,
  input  logic        isMod,
  input  logic        isCmp,
  input  logic        isWb,
  input  logic        isBeq,
  input  logic        isBgt,
  input  logic        isUBranch,
  input  logic        flag_eq,
  input  logic        flag_gt,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        md_start,
  output logic        ir_load,
  output logic        rf_we,
  output logic        flags_we,
  output logic        pc_load,
  output logic        pc_sel,
  output logic        retire,
  output logic        halted,
  output logic        md_err,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MDWAIT = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        md_op, mem_op;
  logic        md_timeout;   // MDWAIT watchdog expired this cycle
  logic        rf_suppress;  // current instruction timed out; block RF write

  assign md_op  = isMul | isDiv | isMod;
  assign mem_op = isLd | isSt;

`ifdef SEQ_MD_TIMEOUT_EN
  localparam int CW = $clog2(MD_TIMEOUT + 1);

  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          md_err_q, md_err_d;
  logic          md_to_q, md_to_d;

  // Watchdog: counter clears entering MDWAIT, fires on its MD_TIMEOUT-th cycle
  always_comb begin
    md_cnt_d   = md_cnt_q;
    md_err_d   = md_err_q;
    md_to_d    = md_to_q;
    md_timeout = 1'b0;
    case (state_q)
      S_EXEC: begin
        md_cnt_d = '0;
        md_to_d  = 1'b0;
      end
      S_MDWAIT: begin
        if (!md_done) begin
          if (md_cnt_q == CW'(MD_TIMEOUT - 1)) begin
            md_timeout = 1'b1;
            md_err_d   = 1'b1;
            md_to_d    = 1'b1;
          end else begin
            md_cnt_d = md_cnt_q + CW'(1);
          end
        end
      end
      S_WB:    md_to_d = 1'b0;
      default: ;
    endcase
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
      md_err_q <= 1'b0;
      md_to_q  <= 1'b0;
    end else begin
      md_cnt_q <= md_cnt_d;
      md_err_q <= md_err_d;
      md_to_q  <= md_to_d;
    end
  end

  assign md_err      = md_err_q;
  assign rf_suppress = md_to_q;
`else
  logic unused_md_timeout;

  assign md_timeout        = 1'b0;
  assign md_err            = 1'b0;
  assign rf_suppress       = 1'b0;
  assign unused_md_timeout = ^MD_TIMEOUT;
`endif

  // State and retire-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HALT;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state: acks are only looked at in their own state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT:   state_d = halt_req ? S_HALT : S_FETCH;
      S_FETCH:  state_d = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (md_op)       state_d = S_MDWAIT;
        else if (mem_op) state_d = S_MEM;
        else             state_d = S_WB;
      end
      S_MDWAIT: state_d = (md_done || md_timeout) ? S_WB : S_MDWAIT;
      S_MEM:    state_d = dmem_ack ? S_WB : S_MEM;
      S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_comb begin
    instr_count_d = instr_count_q;
    if (state_q == S_WB) instr_count_d = instr_count_q + 16'd1;
  end

  // Moore outputs from state plus decoded flags; ir_load is the only ack-gated one
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    md_start = 1'b0;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;
    pc_load  = 1'b0;
    pc_sel   = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_HALT:  halted = 1'b1;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_EXEC:  md_start = md_op;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = isSt;
      end
      S_WB: begin
        rf_we    = isWb & ~rf_suppress;
        flags_we = isCmp;
        pc_load  = 1'b1;
        pc_sel   = isUBranch | (isBeq & flag_eq) | (isBgt & flag_gt);
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule
